// File: rtl/video_types.sv
// +---------------------------------------------------------------+
// | video_types : shared video-subsystem types and address map     |
// | rev 1.0                                                        |
// +---------------------------------------------------------------+
`default_nettype none

package video_types;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int          OAM_SIZE     = 160;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;

endpackage

`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
// +---------------------------------------------------------------+
// | oam_dma_ctrl : CPU-started block copy of XFER_LEN bytes to OAM |
// | rev 1.0                                                        |
// +---------------------------------------------------------------+
`default_nettype none

module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = video_types::DMA_REG_ADDR,
  parameter logic [15:0] OAM_BASE     = video_types::OAM_BASE,
  parameter int          XFER_LEN     = video_types::OAM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic        cpu_hit,
  output logic [7:0]  cpu_rdata,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] m_addr,
  output logic        m_rd,
  input  logic [7:0]  m_rdata,
  output logic        m_wr,
  output logic [7:0]  m_wdata,
  output logic        dma_active,
  output logic        dma_done
);

  import video_types::*;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t  state_q, state_d;
  logic [7:0]  dma_reg_q, dma_reg_d;
  logic [15:0] src_q, src_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        start;

  assign cpu_hit    = (cpu_addr == DMA_REG_ADDR);
  assign start      = cpu_we && cpu_hit;
  assign cpu_rdata  = (cpu_re && cpu_hit) ? dma_reg_q : 8'h00;
  assign dma_active = (state_q != ST_IDLE);
  assign dma_done   = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dma_reg_q <= 8'h00;
      src_q     <= 16'h0000;
      idx_q     <= 8'h00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dma_reg_q <= dma_reg_d;
      src_q     <= src_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dma_reg_d = dma_reg_q;
    src_d     = src_q;
    idx_d     = idx_q;
    data_d    = data_q;
    done_d    = 1'b0;
    bus_req   = 1'b0;
    m_addr    = 16'h0000;
    m_rd      = 1'b0;
    m_wr      = 1'b0;
    m_wdata   = 8'h00;

    // Without grant the strobes drop and every register holds, so the step replays.
    case (state_q)
      ST_IDLE: ;
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) state_d = ST_READ;
      end
      ST_READ: begin
        bus_req = 1'b1;
        m_addr  = src_q + {8'h00, idx_q};
        m_rd    = bus_gnt;
        if (bus_gnt) begin
          data_d  = m_rdata;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        bus_req = 1'b1;
        m_addr  = OAM_BASE + {8'h00, idx_q};
        m_wdata = data_q;
        m_wr    = bus_gnt;
        if (bus_gnt) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A start write restarts from any state; the strobe above still goes out.
    if (start) begin
      dma_reg_d = cpu_wdata;
      src_d     = {cpu_wdata, 8'h00};
      idx_d     = 8'h00;
      state_d   = ST_REQ;
      done_d    = 1'b0;
    end
  end

endmodule

`default_nettype wire
